// File: rtl/traffic_pkg.sv
// Shared lamp codes, monitor states and fault codes for the four-way traffic safety monitor.
package traffic_pkg;

  localparam logic [1:0] CAR_RED    = 2'b00;
  localparam logic [1:0] CAR_GREEN  = 2'b01;
  localparam logic [1:0] CAR_YELLOW = 2'b10;
  localparam logic [1:0] CAR_LEFT   = 2'b11;

  localparam logic [1:0] PED_RED     = 2'b00;
  localparam logic [1:0] PED_GREEN   = 2'b01;
  localparam logic [1:0] PED_BLINK   = 2'b10;
  localparam logic [1:0] PED_ILLEGAL = 2'b11;

  localparam int CYCLE_MAX_DEF = 68;

  typedef enum logic [1:0] {
    ST_INIT    = 2'b00,
    ST_RUN     = 2'b01,
    ST_FAULT   = 2'b10,
    ST_RECOVER = 2'b11
  } mon_state_e;

  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_CAR      = 3'd1;
  localparam logic [2:0] FC_CAR_PED  = 3'd2;
  localparam logic [2:0] FC_PED_CODE = 3'd3;
  localparam logic [2:0] FC_SEQ      = 3'd4;

  // Lamp enable for one pedestrian head: steady for GREEN, follows the blink phase for BLINK.
  function automatic logic ped_lamp(input logic [1:0] code, input logic phase);
    logic on;
    case (code)
      PED_GREEN: on = 1'b1;
      PED_BLINK: on = phase;
      default:   on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Free-running blink phase: toggles every BLINK_HALF clocks, restarts at phase 0 on reset.
module blink_gen #(
  parameter int BLINK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_phase
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_r;

  // Half-period counter and phase flip-flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= '0;
      phase_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r   <= '0;
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      phase_r <= phase_r;
    end
  end

  assign o_phase = phase_r;

endmodule

// File: rtl/traffic_safety_monitor.sv
// Safety stage between the traffic controller and the lamps: passes clean vectors through
// registered, latches a fault and forces all-red flash on any unsafe combination.
module traffic_safety_monitor
  import traffic_pkg::*;
#(
  parameter int CYCLE_MAX  = CYCLE_MAX_DEF,
  parameter int BLINK_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       i_cycle,
  input  logic [7:0]       i_car,
  input  logic [7:0]       i_ped,
  input  logic             i_clr_fault,
  output logic [7:0]       o_car,
  output logic [7:0]       o_ped,
  output logic             o_car_on,
  output logic [3:0]       o_ped_on,
  output logic [1:0]       o_state,
  output logic [2:0]       o_fault_code,
  output logic [CNT_W-1:0] o_fault_cnt
);

  localparam logic [6:0] CYC_LAST = 7'(CYCLE_MAX);

  mon_state_e       state_r, state_nxt_s;
  logic [7:0]       car_r, ped_r;
  logic [2:0]       code_r, code_s;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       prev_cycle_r;
  logic             armed_r;
  logic             phase_s;
  logic             v1_s, v2_s, v3_s, v4_s, viol_s, fault_entry_s;
  logic [3:0]       ped_on_s;

  blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk     (clk),
    .rst     (rst),
    .o_phase (phase_s)
  );

  // Unsafe-combination checks on the current input vector
  always_comb begin
    v1_s = ((i_car[1:0] != CAR_RED) || (i_car[3:2] != CAR_RED)) &&
           ((i_car[5:4] != CAR_RED) || (i_car[7:6] != CAR_RED));
    v2_s = 1'b0;
    v3_s = 1'b0;
    for (int d = 0; d < 4; d++) begin
      v2_s = v2_s | ((i_car[2*d +: 2] != CAR_RED) && (i_ped[2*d +: 2] != PED_RED));
      v3_s = v3_s | (i_ped[2*d +: 2] == PED_ILLEGAL);
    end
    // The upstream counter wraps CYCLE_MAX -> 1, so that step is not a skip.
    v4_s = armed_r && !((i_cycle == prev_cycle_r + 7'd1) ||
                        ((prev_cycle_r == CYC_LAST) && (i_cycle == 7'd1)));
    if (v1_s) begin
      code_s = FC_CAR;
    end else if (v2_s) begin
      code_s = FC_CAR_PED;
    end else if (v3_s) begin
      code_s = FC_PED_CODE;
    end else if (v4_s) begin
      code_s = FC_SEQ;
    end else begin
      code_s = FC_NONE;
    end
    viol_s = (code_s != FC_NONE);
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INIT, ST_RECOVER: begin
        if (viol_s) begin
          state_nxt_s = ST_FAULT;
        end else if (i_cycle == 7'd1) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (viol_s) begin
          state_nxt_s = ST_FAULT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (i_clr_fault) begin
          state_nxt_s = ST_RECOVER;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
    fault_entry_s = (state_nxt_s == ST_FAULT) && (state_r != ST_FAULT);
  end

  // State, lamp outputs, fault bookkeeping; lamps only carry the inputs on edges that land in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_INIT;
      car_r        <= 8'h00;
      ped_r        <= 8'h00;
      code_r       <= FC_NONE;
      cnt_r        <= '0;
      prev_cycle_r <= 7'd0;
      armed_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      prev_cycle_r <= i_cycle;
      armed_r      <= 1'b1;
      if (state_nxt_s == ST_RUN) begin
        car_r <= i_car;
        ped_r <= i_ped;
      end else begin
        car_r <= 8'h00;
        ped_r <= 8'h00;
      end
      if (fault_entry_s) begin
        code_r <= code_s;
      end else if ((state_r == ST_FAULT) && i_clr_fault) begin
        code_r <= FC_NONE;
      end else begin
        code_r <= code_r;
      end
      if (fault_entry_s && (cnt_r != '1)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Pedestrian lamp enables, dark outside RUN
  always_comb begin
    ped_on_s = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      ped_on_s[d] = (state_r == ST_RUN) && ped_lamp(ped_r[2*d +: 2], phase_s);
    end
  end

  assign o_car        = car_r;
  assign o_ped        = ped_r;
  assign o_car_on     = (state_r == ST_RUN) ? 1'b1 : phase_s;
  assign o_ped_on     = ped_on_s;
  assign o_state      = state_r;
  assign o_fault_code = code_r;
  assign o_fault_cnt  = cnt_r;

endmodule

// File: tb/tb_traffic_safety_monitor.sv
// Randomized bench for traffic_safety_monitor with a rule-level reference model and directed scenarios.
module tb_traffic_safety_monitor;

  localparam int CMAX = 68;
  localparam int BH   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] i_cycle;
  logic [7:0] i_car, i_ped;
  logic       i_clr_fault;
  logic [7:0] o_car, o_ped;
  logic       o_car_on;
  logic [3:0] o_ped_on;
  logic [1:0] o_state;
  logic [2:0] o_fault_code;
  logic [7:0] o_fault_cnt;

  always #5 clk = ~clk;

  traffic_safety_monitor #(.CYCLE_MAX(CMAX), .BLINK_HALF(BH), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_cycle(i_cycle), .i_car(i_car), .i_ped(i_ped),
    .i_clr_fault(i_clr_fault), .o_car(o_car), .o_ped(o_ped), .o_car_on(o_car_on),
    .o_ped_on(o_ped_on), .o_state(o_state), .o_fault_code(o_fault_code),
    .o_fault_cnt(o_fault_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 INIT, 1 RUN, 2 FAULT, 3 RECOVER
  int         m_state, m_code, m_cnt, m_edges, m_prev;
  bit         m_armed;
  logic [7:0] m_car, m_ped;
  bit         chk_en = 1'b0;
  int         cur;

  function automatic void model_reset();
    m_state = 0; m_code = 0; m_cnt = 0; m_edges = 0; m_prev = 0; m_armed = 1'b0;
    m_car = 8'h00; m_ped = 8'h00;
  endfunction

  function automatic int viol(input logic [7:0] car, input logic [7:0] ped, input int cyc);
    int c[4];
    int p[4];
    for (int d = 0; d < 4; d++) begin
      c[d] = int'(car[2*d +: 2]);
      p[d] = int'(ped[2*d +: 2]);
    end
    if ((c[0] != 0 || c[1] != 0) && (c[2] != 0 || c[3] != 0)) return 1;
    for (int d = 0; d < 4; d++) if (c[d] != 0 && p[d] != 0) return 2;
    for (int d = 0; d < 4; d++) if (p[d] == 3) return 3;
    if (m_armed && !(cyc == m_prev + 1 || (m_prev == CMAX && cyc == 1))) return 4;
    return 0;
  endfunction

  function automatic void model_edge();
    int v, nxt;
    v = viol(i_car, i_ped, int'(i_cycle));
    if (m_state == 2) nxt = i_clr_fault ? 3 : 2;
    else if (v != 0) nxt = 2;
    else if (m_state == 1 || i_cycle == 7'd1) nxt = 1;
    else nxt = m_state;
    if (nxt == 2 && m_state != 2) begin
      m_code = v;
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (m_state == 2 && i_clr_fault) begin
      m_code = 0;
    end
    m_car   = (nxt == 1) ? i_car : 8'h00;
    m_ped   = (nxt == 1) ? i_ped : 8'h00;
    m_state = nxt;
    m_prev  = int'(i_cycle);
    m_armed = 1'b1;
    m_edges++;
  endfunction

  function automatic logic m_phase();
    return logic'((m_edges / BH) % 2);
  endfunction

  function automatic logic [3:0] m_ped_on();
    logic [3:0] r;
    r = 4'b0000;
    for (int d = 0; d < 4; d++) begin
      if (m_state == 1 && m_ped[2*d +: 2] == 2'b01) r[d] = 1'b1;
      if (m_state == 1 && m_ped[2*d +: 2] == 2'b10) r[d] = m_phase();
    end
    return r;
  endfunction

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", o_state, m_state);
      chk("code", o_fault_code, m_code);
      chk("cnt", o_fault_cnt, m_cnt);
      chk("car", o_car, m_car);
      chk("ped", o_ped, m_ped);
      chk("car_on", o_car_on, (m_state == 1) ? 1'b1 : m_phase());
      chk("ped_on", o_ped_on, m_ped_on());
    end
  end

  function automatic int nxt_cyc(input int c);
    return (c == CMAX) ? 1 : c + 1;
  endfunction

  // Legal four-way plan: N/S serve first (left then through), E/W second
  function automatic void pat(input int c, output logic [7:0] car, output logic [7:0] ped);
    logic [1:0] ns, ew, pns, pew;
    if (c <= 6) ns = 2'b11; else if (c <= 30) ns = 2'b01; else if (c <= 34) ns = 2'b10; else ns = 2'b00;
    if (c >= 35 && c <= 64) ew = 2'b01; else if (c >= 65) ew = 2'b10; else ew = 2'b00;
    pew = (c >= 7 && c <= 26) ? 2'b01 : ((c >= 27 && c <= 30) ? 2'b10 : 2'b00);
    pns = (c >= 37 && c <= 58) ? 2'b01 : ((c >= 59 && c <= 62) ? 2'b10 : 2'b00);
    car = {ew, ew, ns, ns};
    ped = {pew, pew, pns, pns};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic step(input logic [7:0] car_x, input logic [7:0] ped_o, input logic clr);
    logic [7:0] c, p;
    pat(cur, c, p);
    i_cycle = 7'(cur);
    i_car = c ^ car_x;
    i_ped = p | ped_o;
    i_clr_fault = clr;
    tick();
    i_clr_fault = 1'b0;
    cur = nxt_cyc(cur);
  endtask

  task automatic step_legal();
    step(8'h00, 8'h00, 1'b0);
  endtask

  task automatic run_until_run();
    for (int k = 0; k < 2 * CMAX && o_state != 2'b01; k++) step_legal();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cur = 60; i_cycle = 7'd60; i_car = 8'h00; i_ped = 8'h00; i_clr_fault = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) tick();
    chk("rst_state", o_state, 2'b00);
    chk("rst_car", o_car, 8'h00);
    chk("rst_car_on", o_car_on, 1'b0);
    chk("rst_cnt", o_fault_cnt, 8'h00);
    rst = 1'b0;

    // T1: two full plans starting mid-cycle; INIT -> RUN at cycle 1, wraps cleanly
    repeat (2 * CMAX) step_legal();
    chk("t1_state", o_state, 2'b01);
    chk("t1_cnt", o_fault_cnt, 8'h00);
    chk("t1_car59", o_car, 8'h50);
    chk("t1_ped59", o_ped, 8'h0A);

    // T2: E car GREEN while N/S served -> car conflict
    while (cur != 5) step_legal();
    step(8'h10, 8'h00, 1'b0);
    chk("t2_state", o_state, 2'b10);
    chk("t2_code", o_fault_code, 3'd1);
    chk("t2_cnt", o_fault_cnt, 8'd1);
    chk("t2_car", o_car, 8'h00);
    while (cur != 9) step_legal();

    // T3: clear at cycle 9, resync at next cycle 1
    step(8'h00, 8'h00, 1'b1);
    chk("t3_state", o_state, 2'b11);
    chk("t3_code", o_fault_code, 3'd0);
    while (cur != 1) step_legal();
    step_legal();
    chk("t3_run", o_state, 2'b01);
    chk("t3_car1", o_car, 8'h0F);

    // T4: skip 10 -> 12
    while (cur != 11) step_legal();
    cur = 12;
    step_legal();
    chk("t4_state", o_state, 2'b10);
    chk("t4_code", o_fault_code, 3'd4);
    chk("t4_cnt", o_fault_cnt, 8'd2);
    step(8'h00, 8'h00, 1'b1);
    run_until_run();
    while (cur != 1) step_legal();
    step_legal();
    chk("t4_wrap_state", o_state, 2'b01);
    chk("t4_wrap_cnt", o_fault_cnt, 8'd2);

    // T5: illegal N ped plus car conflict together -> car conflict wins and sticks
    while (cur != 3) step_legal();
    step(8'h10, 8'h03, 1'b0);
    chk("t5_code", o_fault_code, 3'd1);
    repeat (3) begin
      step(8'h00, 8'h03, 1'b0);
      chk("t5_hold", o_fault_code, 3'd1);
    end
    chk("t5_cnt", o_fault_cnt, 8'd3);
    step(8'h00, 8'h00, 1'b1);
    run_until_run();

    // Random phase: rare corruptions and skips, frequent clears
    repeat (1500) begin
      int r;
      logic clr;
      r = int'($urandom_range(0, 299));
      clr = ($urandom_range(0, 9) == 0);
      if (r == 2) cur = nxt_cyc(cur);
      if (r == 0) step(8'($urandom), 8'h00, clr);
      else if (r == 1) step(8'h00, 8'($urandom), clr);
      else step(8'h00, 8'h00, clr);
    end

    // T6: reset in the middle of a FAULT cycle
    step(8'h11, 8'h00, 1'b0);
    chk("t6_fault", o_state, 2'b10);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6_state", o_state, 2'b00);
    chk("t6_car", o_car, 8'h00);
    chk("t6_ped", o_ped, 8'h00);
    chk("t6_car_on", o_car_on, 1'b0);
    chk("t6_ped_on", o_ped_on, 4'h0);
    chk("t6_code", o_fault_code, 3'd0);
    chk("t6_cnt", o_fault_cnt, 8'd0);
    repeat (2) tick();
    rst = 1'b0;
    run_until_run();
    chk("t6_run", o_state, 2'b01);
    repeat (3) begin
      step(8'h00, 8'h00, 1'b1);
      chk("t6_clr_run", o_state, 2'b01);
      chk("t6_clr_code", o_fault_code, 3'd0);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
